// File: rtl/rom_loader_pkg.sv
// rom_loader_pkg: shared constants for the ROM download loader.
//   - 3-bit FSM state encodings (also visible on rom_loader.state_dbg)
//   - default frame start byte, length field width, checksum width,
//     and the number of byte lanes packed into one ROM word
package rom_loader_pkg;

    localparam int BYTE_W = 8;
    localparam int LEN_W  = 16;
    localparam int CSUM_W = 8;
    localparam int LANES  = 4;
    localparam int LANE_W = $clog2(LANES);

    localparam logic [BYTE_W-1:0] DEFAULT_MAGIC = 8'hA5;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LEN0 = 3'd1;
    localparam logic [2:0] ST_LEN1 = 3'd2;
    localparam logic [2:0] ST_DATA = 3'd3;
    localparam logic [2:0] ST_CSUM = 3'd4;
    localparam logic [2:0] ST_DONE = 3'd5;
    localparam logic [2:0] ST_ERR  = 3'd6;

endpackage

// File: rtl/rom_loader_if.sv
// rom_loader_if: byte-stream link into the ROM loader.
//   s_valid : source has a byte on s_data
//   s_data  : byte value
//   s_ready : sink can take a byte
// Handshake: a byte transfers on a rising clk edge where s_valid && s_ready;
// the source holds s_data stable while s_valid is high and not yet accepted,
// and may drop s_valid between bytes at any time.
// Modports: master = byte source, slave = loader.
interface rom_loader_if;
    import rom_loader_pkg::*;

    logic              s_valid;
    logic [BYTE_W-1:0] s_data;
    logic              s_ready;

    modport master (output s_valid, output s_data, input s_ready);
    modport slave  (input s_valid, input s_data, output s_ready);

endinterface

// File: rtl/rom_loader_word_pack.sv
// rom_loader_word_pack: packs bytes into little-endian 32-bit words.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   clear       : drop any partial word and restart at lane 0
//   byte_en     : byte_in is accepted this cycle
//   byte_in     : byte value; first byte of a word lands in bits [7:0]
//   last_lane   : the next accepted byte completes a word (lane 3)
//   word_valid  : one-cycle pulse, word holds a freshly completed word
//   word        : last completed word (held until the next one)
module rom_loader_word_pack
    import rom_loader_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic                    byte_en,
    input  logic [BYTE_W-1:0]       byte_in,
    output logic                    last_lane,
    output logic                    word_valid,
    output logic [LANES*BYTE_W-1:0] word
);

    localparam logic [LANE_W-1:0] LAST = LANE_W'(LANES - 1);

    logic [LANE_W-1:0]           lane;
    // Lower three bytes shift in from the top so the first byte ends up lowest.
    logic [(LANES-1)*BYTE_W-1:0] low_bytes;

    assign last_lane = (lane == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane       <= '0;
            low_bytes  <= '0;
            word_valid <= 1'b0;
            word       <= '0;
        end else begin
            word_valid <= 1'b0;
            if (clear) begin
                lane      <= '0;
                low_bytes <= '0;
            end else if (byte_en) begin
                if (last_lane) begin
                    word       <= {byte_in, low_bytes};
                    word_valid <= 1'b1;
                    lane       <= '0;
                end else begin
                    low_bytes <= {byte_in, low_bytes[(LANES-1)*BYTE_W-1:BYTE_W]};
                    lane      <= lane + LANE_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/rom_loader.sv
// rom_loader: downloads a framed byte stream into the instruction ROM and
// holds the core in reset until a complete image with a good checksum is in.
// Frame: MAGIC, LEN_LO, LEN_HI (word count N), 4*N payload bytes, CSUM
// (XOR of all payload bytes).
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   bs            : byte stream (rom_loader_if.slave), never backpressured
//   rom_we        : one-cycle write strobe per word
//   rom_waddr     : word address of the write
//   rom_wdata     : packed word of the write
//   core_rst_n    : core reset, released only after a good image
//   busy          : a frame is in progress
//   done          : a good image is loaded
//   err           : last frame failed (sticky until the next MAGIC)
//   state_dbg     : current FSM state (rom_loader_pkg ST_* encodings)
// Optional: define ROM_LOADER_TIMEOUT_EN to abort a frame into ERR after
// TIMEOUT_CYCLES consecutive cycles without an accepted byte.
module rom_loader
    import rom_loader_pkg::*;
#(
    parameter int                ADDR_WIDTH     = 12,
    parameter int                DATA_WIDTH     = 32,
    parameter logic [BYTE_W-1:0] MAGIC          = DEFAULT_MAGIC,
    parameter int                TIMEOUT_CYCLES = 1000000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    rom_loader_if.slave           bs,
    output logic                  rom_we,
    output logic [ADDR_WIDTH-1:0] rom_waddr,
    output logic [DATA_WIDTH-1:0] rom_wdata,
    output logic                  core_rst_n,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [2:0]            state_dbg
);

    // One extra bit so a count of exactly 2**ADDR_WIDTH words is representable.
    localparam int                CNT_W     = LEN_W + 1;
    localparam logic [CNT_W-1:0] MAX_WORDS = CNT_W'(1) << ADDR_WIDTH;

    // A non-positive timeout would abort every frame immediately.
    if (TIMEOUT_CYCLES <= 0) begin : g_timeout_must_be_positive
    end

    logic [2:0]        state;
    logic [BYTE_W-1:0] len_lo;
    logic [LEN_W-1:0]  len;
    logic [CNT_W-1:0]  wcnt;
    logic [CNT_W-1:0]  wcnt_nxt;
    logic [CSUM_W-1:0] csum;
    logic [LEN_W-1:0]  len_in;
    logic              accept;
    logic              is_magic;
    logic              pk_last;
    logic              timeout_hit;

    assign bs.s_ready = 1'b1;
    assign accept     = bs.s_valid;
    assign is_magic   = (bs.s_data == MAGIC);
    assign len_in     = {bs.s_data, len_lo};
    assign wcnt_nxt   = wcnt + CNT_W'(1);
    assign state_dbg  = state;

    rom_loader_word_pack u_pack (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (accept && state == ST_LEN1),
        .byte_en    (accept && state == ST_DATA),
        .byte_in    (bs.s_data),
        .last_lane  (pk_last),
        .word_valid (rom_we),
        .word       (rom_wdata)
    );

`ifdef ROM_LOADER_TIMEOUT_EN
    logic [31:0] idle_cnt;
    logic        in_frame;

    assign in_frame    = (state == ST_LEN0) || (state == ST_LEN1) ||
                         (state == ST_DATA) || (state == ST_CSUM);
    assign timeout_hit = in_frame && !accept &&
                         (idle_cnt + 32'd1 >= 32'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
        end else if (accept || !in_frame) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + 32'd1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            len_lo     <= '0;
            len        <= '0;
            wcnt       <= '0;
            csum       <= '0;
            rom_waddr  <= '0;
            core_rst_n <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else if (accept) begin
            case (state)
                ST_IDLE: begin
                    if (is_magic) begin
                        state <= ST_LEN0;
                        busy  <= 1'b1;
                    end
                end
                ST_LEN0: begin
                    len_lo <= bs.s_data;
                    state  <= ST_LEN1;
                end
                ST_LEN1: begin
                    len  <= len_in;
                    wcnt <= '0;
                    csum <= '0;
                    if ({1'b0, len_in} > MAX_WORDS) begin
                        state <= ST_ERR;
                        err   <= 1'b1;
                        busy  <= 1'b0;
                    end else if (len_in == '0) begin
                        state <= ST_CSUM;
                    end else begin
                        state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    csum <= csum ^ bs.s_data;
                    // The packer raises rom_we next cycle; the address is
                    // registered alongside so both line up.
                    if (pk_last) begin
                        rom_waddr <= wcnt[ADDR_WIDTH-1:0];
                        wcnt      <= wcnt_nxt;
                        if (wcnt_nxt == {1'b0, len}) begin
                            state <= ST_CSUM;
                        end
                    end
                end
                ST_CSUM: begin
                    busy <= 1'b0;
                    if (bs.s_data == csum) begin
                        state      <= ST_DONE;
                        done       <= 1'b1;
                        core_rst_n <= 1'b1;
                    end else begin
                        state <= ST_ERR;
                        err   <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (is_magic) begin
                        state      <= ST_LEN0;
                        done       <= 1'b0;
                        core_rst_n <= 1'b0;
                        busy       <= 1'b1;
                    end
                end
                ST_ERR: begin
                    if (is_magic) begin
                        state <= ST_LEN0;
                        err   <= 1'b0;
                        busy  <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end else if (timeout_hit) begin
            state <= ST_ERR;
            err   <= 1'b1;
            busy  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rom_loader.sv
// tb_rom_loader: directed-vector bench for rom_loader.
// Build with ROM_LOADER_TIMEOUT_EN defined to exercise the inactivity abort
// (TIMEOUT_CYCLES is set to 50 here).
module tb_rom_loader;
    import rom_loader_pkg::*;

    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rom_we;
    logic [AW-1:0] rom_waddr;
    logic [31:0]   rom_wdata;
    logic          core_rst_n;
    logic          busy;
    logic          done;
    logic          err;
    logic [2:0]    state_dbg;

    rom_loader_if bs_if ();

    rom_loader #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (32),
        .MAGIC          (8'hA5),
        .TIMEOUT_CYCLES (50)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bs         (bs_if.slave),
        .rom_we     (rom_we),
        .rom_waddr  (rom_waddr),
        .rom_wdata  (rom_wdata),
        .core_rst_n (core_rst_n),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .state_dbg  (state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- scoreboard ----------------
    // Each entry is {address, data} of one ROM write the DUT still owes.
    logic [AW+31:0] exp_q[$];

    always @(negedge clk) begin
        if (rst_n && rom_we) begin
            if (exp_q.size() == 0) begin
                chk("wr_unexpected", 64'(rom_we), 64'd0);
            end else begin
                logic [AW+31:0] e;
                e = exp_q.pop_front();
                chk("wr_addr", 64'(rom_waddr), 64'(e[AW+31:32]));
                chk("wr_data", 64'(rom_wdata), 64'(e[31:0]));
            end
        end
    end

    // ---------------- drivers ----------------
    // All drivers start and end 1 time unit after a rising edge.
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bs_if.s_valid = 1'b1;
        bs_if.s_data  = b;
        @(posedge clk);
        #1;
        bs_if.s_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        chk("rst_state", 64'(state_dbg), 64'(ST_IDLE));
        chk("rst_core", 64'(core_rst_n), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_we", 64'(rom_we), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] xor_words(input logic [31:0] w[4], input int n);
        logic [7:0] x;
        x = 8'h00;
        for (int i = 0; i < n; i++) begin
            x = x ^ w[i][7:0] ^ w[i][15:8] ^ w[i][23:16] ^ w[i][31:24];
        end
        return x;
    endfunction

    // MAGIC, length, payload; expected writes are queued first. gap_max > 0
    // inserts 1..gap_max idle cycles after each payload byte.
    task automatic send_head_payload(input logic [15:0] n, input logic [31:0] w[4],
                                     input int gap_max);
        for (int i = 0; i < int'(n); i++) exp_q.push_back({AW'(i), w[i]});
        send_byte(8'hA5);
        send_byte(n[7:0]);
        send_byte(n[15:8]);
        for (int i = 0; i < int'(n); i++) begin
            for (int j = 0; j < 4; j++) begin
                send_byte(w[i][8*j +: 8]);
                if (gap_max > 0) idle($urandom_range(1, gap_max));
            end
        end
    endtask

    // ---------------- directed sequence ----------------
    logic [31:0] img_a[4];
    logic [7:0]  csum_a;

    initial begin
        bs_if.s_valid = 1'b0;
        bs_if.s_data  = 8'h00;
        img_a = '{32'h0000_0013, 32'h0010_0093, 32'h0, 32'h0};
        // 13 ^ 93 ^ 10 = 90
        csum_a = 8'h90;

        // Reset values.
        #2;
        chk("rst_ready", 64'(bs_if.s_ready), 64'd1);
        chk("rst_waddr", 64'(rom_waddr), 64'd0);
        chk("rst_wdata", 64'(rom_wdata), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        do_reset();

        // Two-word image, back-to-back bytes.
        chk("csum_model", 64'(xor_words(img_a, 2)), 64'(csum_a));
        send_head_payload(16'd2, img_a, 0);
        chk("a_busy", 64'(busy), 64'd1);
        chk("a_state_csum", 64'(state_dbg), 64'(ST_CSUM));
        chk("a_done_early", 64'(done), 64'd0);
        send_byte(csum_a);
        chk("a_done", 64'(done), 64'd1);
        chk("a_core", 64'(core_rst_n), 64'd1);
        chk("a_busy_end", 64'(busy), 64'd0);

        // Reload from DONE with a bad checksum.
        send_byte(8'hA5);
        chk("reload_core", 64'(core_rst_n), 64'd0);
        chk("reload_done", 64'(done), 64'd0);
        chk("reload_busy", 64'(busy), 64'd1);
        exp_q.push_back({AW'(0), img_a[0]});
        exp_q.push_back({AW'(1), img_a[1]});
        send_byte(8'h02); send_byte(8'h00);
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 4; j++) send_byte(img_a[i][8*j +: 8]);
        send_byte(8'h81);
        chk("bad_err", 64'(err), 64'd1);
        chk("bad_core", 64'(core_rst_n), 64'd0);
        chk("bad_done", 64'(done), 64'd0);
        chk("bad_state", 64'(state_dbg), 64'(ST_ERR));

        // Junk in ERR is ignored; a good frame recovers.
        send_byte(8'h00);
        chk("err_junk", 64'(state_dbg), 64'(ST_ERR));
        send_head_payload(16'd2, img_a, 0);
        chk("rec_err_clr", 64'(err), 64'd0);
        send_byte(csum_a);
        chk("rec_done", 64'(done), 64'd1);
        chk("rec_core", 64'(core_rst_n), 64'd1);

        // Zero-length frame: no writes, checksum 00.
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00);
        chk("zero_state", 64'(state_dbg), 64'(ST_CSUM));
        send_byte(8'h00);
        chk("zero_done", 64'(done), 64'd1);

        // N = 0x1001 exceeds 4096 words.
        send_byte(8'hA5); send_byte(8'h01);
        chk("big_before", 64'(err), 64'd0);
        send_byte(8'h10);
        chk("big_err", 64'(err), 64'd1);
        chk("big_state", 64'(state_dbg), 64'(ST_ERR));
        chk("big_core", 64'(core_rst_n), 64'd0);

        // Junk before MAGIC in IDLE, payload with gaps.
        do_reset();
        send_byte(8'h00); send_byte(8'hFF);
        chk("junk_state", 64'(state_dbg), 64'(ST_IDLE));
        chk("junk_busy", 64'(busy), 64'd0);
        send_head_payload(16'd2, img_a, 5);
        send_byte(csum_a);
        chk("gap_done", 64'(done), 64'd1);

        // Stall mid-payload after two bytes.
        send_byte(8'hA5);
        chk("stall_core", 64'(core_rst_n), 64'd0);
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h13); send_byte(8'h00);
`ifdef ROM_LOADER_TIMEOUT_EN
        idle(49);
        chk("to_not_yet", 64'(err), 64'd0);
        idle(1);
        chk("to_err", 64'(err), 64'd1);
        chk("to_state", 64'(state_dbg), 64'(ST_ERR));
        chk("to_busy", 64'(busy), 64'd0);
`else
        idle(60);
        chk("stall_err", 64'(err), 64'd0);
        chk("stall_state", 64'(state_dbg), 64'(ST_DATA));
        chk("stall_busy", 64'(busy), 64'd1);
`endif
        do_reset();

        // Reset mid-DATA after one full word: only word 0 is written.
        exp_q.push_back({AW'(0), img_a[0]});
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
        for (int j = 0; j < 4; j++) send_byte(img_a[0][8*j +: 8]);
        send_byte(8'h93); send_byte(8'h00);
        do_reset();
        idle(10);
        chk("mid_done", 64'(done), 64'd0);

        // N = 0x1000 is exactly the ROM depth and is accepted.
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h10);
        chk("max_state", 64'(state_dbg), 64'(ST_DATA));
        chk("max_err", 64'(err), 64'd0);
        do_reset();

        idle(3);
        chk("wr_missing", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    // Watchdog: no directed sequence here needs anywhere near this long.
    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
